// File: rtl/clk_step_gen.sv
// Slow, glitch-free clock generator with a runtime-programmable half-period.
// Modes: free-run, halt and single-step from a debounced push-button.
// Also provides a rising-edge tick and a count of completed periods for debug.
module clk_step_gen #(
  parameter int unsigned CNT_WIDTH    = 27,
  parameter int unsigned DEFAULT_HALF = 75000000,
  parameter int unsigned DEB_WIDTH    = 20,
  parameter int unsigned DEB_CYCLES   = 1000000
) (
  input  logic                 clk_signal,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 step_btn,
  input  logic                 half_we,
  input  logic [CNT_WIDTH-1:0] half_in,
  output logic                 clk_out,
  output logic                 rise_tick,
  output logic                 busy,
  output logic [31:0]          period_cnt
);

  localparam logic [1:0]           ModeRun   = 2'b01;
  localparam logic [1:0]           ModeStep  = 2'b10;
  localparam logic [CNT_WIDTH-1:0] HalfReset = CNT_WIDTH'(DEFAULT_HALF);
  localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);
  localparam logic [DEB_WIDTH-1:0] DebLast   = DEB_WIDTH'(DEB_CYCLES - 1);
  localparam logic [DEB_WIDTH-1:0] DebOne    = DEB_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] live_q;
  logic [CNT_WIDTH-1:0] shadow_q;
  logic [CNT_WIDTH-1:0] shadow_d;
  logic                 sync1_q;
  logic                 sync2_q;
  logic                 level_q;
  logic [DEB_WIDTH-1:0] deb_cnt_q;
  logic                 pending_q;

  logic run_mode;
  logic step_mode;
  logic tc;
  logic deb_flip;
  logic deb_rise;
  logic step_take;

  // Decode mode, terminal count, debounce flip and step consumption.
  always_comb begin
    run_mode  = (mode == ModeRun);
    step_mode = (mode == ModeStep);
    shadow_d  = shadow_q;
    if (half_we) begin
      shadow_d = (half_in == '0) ? CntOne : half_in;
    end
    tc        = (cnt_q == (live_q - CntOne));
    deb_flip  = (sync2_q != level_q) && (deb_cnt_q == DebLast);
    deb_rise  = deb_flip && !level_q;
    step_take = (state_q == StIdle) && step_mode && pending_q;
  end

  // Main phase FSM; clk_out, rise_tick and busy are registered decodes of the next state.
  always_ff @(posedge clk_signal) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      live_q     <= HalfReset;
      clk_out    <= 1'b0;
      rise_tick  <= 1'b0;
      busy       <= 1'b0;
      period_cnt <= '0;
    end else begin
      rise_tick <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Half-period changes are free to land while idle.
          live_q <= shadow_d;
          if (run_mode || step_take) begin
            state_q   <= StHigh;
            cnt_q     <= '0;
            clk_out   <= 1'b1;
            rise_tick <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StHigh: begin
          // High phase always runs to completion, whatever the mode does.
          if (tc) begin
            state_q <= StLow;
            cnt_q   <= '0;
            clk_out <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StLow: begin
          if (tc) begin
            period_cnt <= period_cnt + 32'd1;
            live_q     <= shadow_d;
            cnt_q      <= '0;
            if (run_mode) begin
              state_q   <= StHigh;
              clk_out   <= 1'b1;
              rise_tick <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          clk_out <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Two-flop synchroniser followed by a stability-count debouncer.
  always_ff @(posedge clk_signal) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q <= step_btn;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        deb_cnt_q <= '0;
      end else if (deb_flip) begin
        level_q   <= sync2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DebOne;
      end
    end
  end

  // Shadow half-period and the single-entry step queue.
  always_ff @(posedge clk_signal) begin
    if (!reset) begin
      shadow_q  <= HalfReset;
      pending_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      // A fresh press wins over consumption so it is not lost on the take cycle.
      if (!step_mode) begin
        pending_q <= 1'b0;
      end else if (deb_rise) begin
        pending_q <= 1'b1;
      end else if (step_take) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_step_gen.sv
// Bench for clk_step_gen: a period-level reference model predicts each rising edge
// (edge index and period count) into a queue; a monitor pops on every rise_tick and
// also checks clk_out, busy and period_cnt each cycle against the model.
module tb_clk_step_gen;

  localparam int unsigned CW = 8;
  localparam int unsigned DH = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned DC = 3;

  logic          clk_signal = 1'b0;
  logic          reset      = 1'b0;
  logic [1:0]    mode       = 2'b00;
  logic          step_btn   = 1'b0;
  logic          half_we    = 1'b0;
  logic [CW-1:0] half_in    = '0;
  logic          clk_out;
  logic          rise_tick;
  logic          busy;
  logic [31:0]   period_cnt;

  clk_step_gen #(
    .CNT_WIDTH   (CW),
    .DEFAULT_HALF(DH),
    .DEB_WIDTH   (DW),
    .DEB_CYCLES  (DC)
  ) dut (
    .clk_signal(clk_signal),
    .reset     (reset),
    .mode      (mode),
    .step_btn  (step_btn),
    .half_we   (half_we),
    .half_in   (half_in),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .busy      (busy),
    .period_cnt(period_cnt)
  );

  always #5 clk_signal = ~clk_signal;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          edge_no;
    int unsigned pcnt;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_ev;

  // Reference model state, indexed by clock edge number.
  int          m_e       = 0;
  int          m_rise    = 0;
  int          m_half    = DH;
  int unsigned m_shadow  = DH;
  int unsigned m_pcnt    = 0;
  bit          m_active  = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_level   = 1'b0;
  bit          m_btn_hist[$];
  bit          m_obs[$];

  task automatic check(input string name, input longint act, input longint want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, m_e, act, want);
    end
  endtask

  // Advance the model over the coming clock edge using the inputs now on the pins.
  task automatic model_edge();
    bit          cmp;
    bit          all_diff;
    bit          lvl_rise;
    bit          start;
    bit          consume;
    int unsigned sh_n;
    m_e++;
    if (!reset) begin
      m_active  = 1'b0;
      m_shadow  = DH;
      m_pending = 1'b0;
      m_level   = 1'b0;
      m_pcnt    = 0;
      m_btn_hist.delete();
      m_obs.delete();
      return;
    end
    // The button reaches the debouncer two edges after it is sampled.
    cmp = (m_btn_hist.size() >= 2) ? m_btn_hist[m_btn_hist.size()-2] : 1'b0;
    m_btn_hist.push_back(step_btn);
    if (m_btn_hist.size() > 4) void'(m_btn_hist.pop_front());
    m_obs.push_back(cmp);
    if (m_obs.size() > DC) void'(m_obs.pop_front());
    // The level follows once DC consecutive observations all disagree with it.
    all_diff = (m_obs.size() == DC);
    foreach (m_obs[i]) if (m_obs[i] == m_level) all_diff = 1'b0;
    lvl_rise = 1'b0;
    if (all_diff) begin
      m_level  = !m_level;
      lvl_rise = m_level;
    end

    sh_n    = half_we ? ((half_in == 0) ? 1 : int'(half_in)) : m_shadow;
    start   = 1'b0;
    consume = 1'b0;
    if (m_active) begin
      if (m_e - m_rise == 2 * m_half) begin
        m_pcnt++;
        m_active = 1'b0;
        if (mode == 2'b01) start = 1'b1;
      end
    end else if (mode == 2'b01) begin
      start = 1'b1;
    end else if (mode == 2'b10 && m_pending) begin
      start   = 1'b1;
      consume = 1'b1;
    end

    if (mode != 2'b10) m_pending = 1'b0;
    else if (lvl_rise) m_pending = 1'b1;
    else if (consume)  m_pending = 1'b0;

    if (start) begin
      m_active = 1'b1;
      m_rise   = m_e;
      m_half   = int'(sh_n);
      exp_q.push_back('{edge_no: m_e, pcnt: m_pcnt});
    end
    m_shadow = sh_n;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_signal);
    @(negedge clk_signal);
    half_we = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int len);
    step_btn = 1'b1;
    ticks(len);
    step_btn = 1'b0;
  endtask

  // Monitor: compare outputs against the model shortly after each active edge.
  always @(posedge clk_signal) begin
    #1;
    check("clk_out", clk_out, (m_active && (m_e - m_rise) < m_half));
    check("busy", busy, m_active);
    check("period_cnt", period_cnt, m_pcnt);
    if (rise_tick) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rise_tick", 1, 0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("rise_edge", m_e, mon_ev.edge_no);
        check("rise_period_cnt", period_cnt, mon_ev.pcnt);
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_no <= m_e) begin
      mon_ev = exp_q.pop_front();
      check("missing_rise_tick", m_e, mon_ev.edge_no - 1);
    end
  end

  initial begin
    // Reset with RUN selected, then free-run.
    mode = 2'b01;
    ticks(3);
    check("rst_clk_out", clk_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rise_tick", rise_tick, 0);
    check("rst_period_cnt", period_cnt, 0);
    reset = 1'b1;
    ticks(25);
    check("run_three_periods", period_cnt, 3);

    // Drop to HALT on the second high cycle of a period.
    for (int i = 0; i < 20 && !(m_active && m_e - m_rise == 0); i++) tick();
    tick();
    mode = 2'b00;
    ticks(12);
    check("halt_clk_out", clk_out, 0);
    check("halt_busy", busy, 0);
    check("halt_period_cnt", period_cnt, 4);

    // STEP: long press with a one-cycle glitch, then a short press that must not step.
    mode = 2'b10;
    step_btn = 1'b1; ticks(2);
    step_btn = 1'b0; ticks(1);
    step_btn = 1'b1; ticks(7);
    step_btn = 1'b0; ticks(20);
    check("step_one_period", period_cnt, 5);
    press(2);
    ticks(20);
    check("short_press_ignored", period_cnt, 5);

    // Overlapping presses: queued while a step period runs.
    for (int i = 0; i < 12; i++) begin
      press($urandom_range(3, 6));
      ticks($urandom_range(1, 12));
    end
    ticks(30);

    // RUN with half-period rewrites landing at random points.
    mode = 2'b01;
    for (int i = 0; i < 20; i++) begin
      half_we = 1'b1;
      half_in = CW'($urandom_range(0, 5));
      ticks($urandom_range(1, 15));
    end

    // Reset in the middle of a low phase, with a step possibly pending.
    half_we = 1'b1;
    half_in = CW'(6);
    ticks(20);
    for (int i = 0; i < 40 && !(m_active && m_e - m_rise == m_half + 1); i++) tick();
    mode = 2'b10;
    step_btn = 1'b1;
    reset = 1'b0;
    tick();
    check("midrst_clk_out", clk_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_period_cnt", period_cnt, 0);
    step_btn = 1'b0;
    reset = 1'b1;
    ticks(10);
    check("midrst_no_stale_step", busy, 0);
    mode = 2'b01;
    ticks(17);
    check("midrst_default_half", period_cnt, 2);

    // Random mixture of modes, presses, rewrites and occasional resets.
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      mode = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      if ($urandom_range(0, 3) == 0) begin
        half_we = 1'b1;
        half_in = CW'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) press($urandom_range(1, 6));
      ticks($urandom_range(1, 20));
    end

    mode = 2'b00;
    ticks(40);
    check("final_idle", busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
